// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with built-in test patterns.
// Counters run on the pixel clock; every pin-side output is registered once.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = 4,
    parameter int CNT_W     = 11
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [1:0]             mode_i,
    input  logic [3*COLOR_W-1:0]   pixel_i,
    output logic                   pixel_req_o,
    output logic [CNT_W-1:0]       x_o,
    output logic [CNT_W-1:0]       y_o,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   de_o,
    output logic                   frame_start_o,
    output logic                   line_start_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int BAR_W   = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_WHITE = 2'd3
    } mode_e;

    logic [CNT_W-1:0]     h_cnt;
    logic [CNT_W-1:0]     v_cnt;
    logic [CNT_W-1:0]     bar_cnt;
    logic [2:0]           bar_idx;
    mode_e                mode_q;
    mode_e                mode_cur;
    logic                 h_last;
    logic                 v_last;
    logic                 at_origin;
    logic                 hs_act;
    logic                 vs_act;
    logic [3*COLOR_W-1:0] pat;

    assign h_last      = (h_cnt == H_LAST);
    assign v_last      = (v_cnt == V_LAST);
    assign at_origin   = (h_cnt == '0) && (v_cnt == '0);
    assign pixel_req_o = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign x_o         = h_cnt;
    assign y_o         = v_cnt;
    assign hs_act      = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_act      = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    // New mode applies to the origin pixel itself, so a frame is never mixed.
    assign mode_cur = at_origin ? mode_e'(mode_i) : mode_q;

    // Raster counters: h wraps every line, v wraps every frame.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (enable_i) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Bar position tracked alongside h_cnt so no divider is needed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (enable_i) begin
            if (h_last) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end
    end

    // Pattern selection is held for the whole frame once sampled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mode_q <= MODE_EXT;
        end else if (enable_i && at_origin) begin
            mode_q <= mode_e'(mode_i);
        end
    end

    // Pixel colour for the current raster position, before blanking.
    always_comb begin
        pat = '0;
        unique case (mode_cur)
            MODE_EXT:   pat = pixel_i;
            MODE_BARS:  pat = {{COLOR_W{~bar_idx[1]}},
                               {COLOR_W{~bar_idx[2]}},
                               {COLOR_W{~bar_idx[0]}}};
            MODE_CHECK: pat = {3*COLOR_W{h_cnt[5] ^ v_cnt[5]}};
            MODE_WHITE: pat = '1;
        endcase
    end

    // Pin outputs, all delayed by one enabled cycle to stay aligned.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            hsync_o       <= ~HSYNC_POL;
            vsync_o       <= ~VSYNC_POL;
            de_o          <= 1'b0;
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
        end else if (enable_i) begin
            {red_o, green_o, blue_o} <= pixel_req_o ? pat : '0;
            hsync_o       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync_o       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            de_o          <= pixel_req_o;
            frame_start_o <= at_origin;
            line_start_o  <= (h_cnt == '0) && (v_cnt < V_VIS);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench with a short vertical timing so whole
// frames fit in a small cycle budget; horizontal timing stays at 640x480 defaults.
module tb_vga_timing_gen;

    localparam int HT    = 800;
    localparam int VV    = 34;
    localparam int VT    = 38;
    localparam int FRAME = HT * VT;

    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [1:0]  mode_i;
    logic [11:0] pixel_i;
    logic        pixel_req_o, pixel_req2;
    logic [10:0] x_o, y_o, x2, y2;
    logic [3:0]  red_o, green_o, blue_o, r2, g2, b2;
    logic        hsync_o, vsync_o, de_o, frame_start_o, line_start_o;
    logic        hsync2, vsync2, de2, fs2, ls2;
    logic [11:0] rgb;
    logic [39:0] obs;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int fs_cyc;

    assign pixel_i = {x_o[3:0], y_o[3:0], 4'hA};
    assign rgb     = {red_o, green_o, blue_o};
    assign obs     = {rgb, hsync_o, vsync_o, de_o, frame_start_o,
                      line_start_o, pixel_req_o, x_o, y_o};

    vga_timing_gen #(.V_VISIBLE(VV), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .mode_i(mode_i), .pixel_i(pixel_i), .pixel_req_o(pixel_req_o),
        .x_o(x_o), .y_o(y_o), .red_o(red_o), .green_o(green_o),
        .blue_o(blue_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .frame_start_o(frame_start_o), .line_start_o(line_start_o)
    );

    vga_timing_gen #(.V_VISIBLE(VV), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .HSYNC_POL(1'b1)) dut_pol (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .mode_i(mode_i), .pixel_i(pixel_i), .pixel_req_o(pixel_req2),
        .x_o(x2), .y_o(y2), .red_o(r2), .green_o(g2), .blue_o(b2),
        .hsync_o(hsync2), .vsync_o(vsync2), .de_o(de2),
        .frame_start_o(fs2), .line_start_o(ls2)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] exp_rgb(input int hh, input int vv, input int md);
        logic [31:0] h;
        logic [31:0] v;
        int idx;
        h = hh;
        v = vv;
        if (hh >= 640 || vv >= VV) return 12'h000;
        case (md)
            0: return {h[3:0], v[3:0], 4'hA};
            1: begin
                idx = hh / 80;
                if (idx > 7) idx = 7;
                return BARS[idx];
            end
            2: return (h[5] ^ v[5]) ? 12'hFFF : 12'h000;
            default: return 12'hFFF;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        reset_i  = 1'b1;
        enable_i = 1'b1;
        mode_i   = 2'd1;
        repeat (3) tick;
        tests++; if (rgb !== 12'h000) begin fails++;
            $display("FAIL reset_rgb: got %h want 000", rgb); end
        tests++; if (hsync_o !== 1'b1) begin fails++;
            $display("FAIL reset_hsync: got %b want 1", hsync_o); end
        tests++; if (vsync_o !== 1'b1) begin fails++;
            $display("FAIL reset_vsync: got %b want 1", vsync_o); end
        tests++; if (hsync2 !== 1'b0) begin fails++;
            $display("FAIL reset_hsync_pol1: got %b want 0", hsync2); end
        tests++; if ({de_o, frame_start_o, line_start_o} !== 3'b000) begin fails++;
            $display("FAIL reset_de_pulses: got %b want 000",
                     {de_o, frame_start_o, line_start_o}); end
        tests++; if (x_o !== 11'd0 || y_o !== 11'd0) begin fails++;
            $display("FAIL reset_xy: got %0d,%0d want 0,0", x_o, y_o); end
    endtask

    task automatic test_enable_freeze;
        logic [39:0] snap;
        int bad;
        snap = obs;
        bad = 0;
        enable_i = 1'b0;
        repeat (50) begin
            tick;
            if (obs !== snap) bad++;
        end
        tests++; if (bad !== 0) begin fails++;
            $display("FAIL freeze_hold: got %0d changed cycles want 0", bad); end
        tests++; if (x_o !== 11'd700 || y_o !== 11'd2) begin fails++;
            $display("FAIL freeze_pos: got %0d,%0d want 700,2", x_o, y_o); end
        enable_i = 1'b1;
    endtask

    task automatic test_frame_bars;
        int hh, vv;
        int e_hs, e_hs2, e_vs, e_de, e_rgb, e_fs, e_ls, e_xy, n_de, n_vs;
        logic exp_hs, exp_vs, exp_de;
        e_hs = 0; e_hs2 = 0; e_vs = 0; e_de = 0; e_rgb = 0;
        e_fs = 0; e_ls = 0; e_xy = 0; n_de = 0; n_vs = 0;
        reset_i = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            tick;
            hh = k % HT;
            vv = k / HT;
            if (k == 0) fs_cyc = cyc;
            exp_hs = !(hh >= 656 && hh <= 751);
            exp_vs = !(vv >= 35 && vv <= 36);
            exp_de = (hh < 640) && (vv < VV);
            if (hsync_o !== exp_hs) e_hs++;
            if (hsync2 !== !exp_hs) e_hs2++;
            if (vsync_o !== exp_vs) e_vs++;
            if (de_o !== exp_de) e_de++;
            if (rgb !== exp_rgb(hh, vv, 1)) e_rgb++;
            if (frame_start_o !== (hh == 0 && vv == 0)) e_fs++;
            if (line_start_o !== (hh == 0 && vv < VV)) e_ls++;
            if (x_o !== 11'(((k + 1) % HT)) || y_o !== 11'((((k + 1) / HT) % VT)))
                e_xy++;
            if (de_o) n_de++;
            if (!vsync_o) n_vs++;
            if (hh == 699 && vv == 2) test_enable_freeze;
            if (hh == 299 && vv == 20) mode_i = 2'd2;
        end
        tests++; if (e_hs !== 0) begin fails++;
            $display("FAIL hsync_window: got %0d bad cycles want 0", e_hs); end
        tests++; if (e_hs2 !== 0) begin fails++;
            $display("FAIL hsync_pol1_window: got %0d bad cycles want 0", e_hs2); end
        tests++; if (e_vs !== 0) begin fails++;
            $display("FAIL vsync_window: got %0d bad cycles want 0", e_vs); end
        tests++; if (e_de !== 0) begin fails++;
            $display("FAIL de_window: got %0d bad cycles want 0", e_de); end
        tests++; if (e_rgb !== 0) begin fails++;
            $display("FAIL bars_rgb: got %0d bad cycles want 0", e_rgb); end
        tests++; if (e_fs !== 0 || e_ls !== 0) begin fails++;
            $display("FAIL start_pulses: got %0d/%0d bad cycles want 0/0", e_fs, e_ls); end
        tests++; if (e_xy !== 0) begin fails++;
            $display("FAIL xy_count: got %0d bad cycles want 0", e_xy); end
        tests++; if (n_de !== 640 * VV) begin fails++;
            $display("FAIL de_count: got %0d want %0d", n_de, 640 * VV); end
        tests++; if (n_vs !== 1600) begin fails++;
            $display("FAIL vsync_count: got %0d want 1600", n_vs); end
    endtask

    task automatic test_checker;
        int hh, vv, e_rgb;
        e_rgb = 0;
        for (int k = FRAME; k <= FRAME + 33 * HT + 64; k++) begin
            tick;
            hh = (k - FRAME) % HT;
            vv = (k - FRAME) / HT;
            if (k == FRAME) begin
                tests++; if (frame_start_o !== 1'b1) begin fails++;
                    $display("FAIL frame2_start: got %b want 1", frame_start_o); end
                tests++; if (cyc - fs_cyc !== FRAME + 50) begin fails++;
                    $display("FAIL frame_period: got %0d want %0d",
                             cyc - fs_cyc, FRAME + 50); end
            end
            if (hh == 32 && vv == 0) begin
                tests++; if (rgb !== 12'hFFF) begin fails++;
                    $display("FAIL checker_32_0: got %h want FFF", rgb); end
            end
            if (hh == 32 && vv == 32) begin
                tests++; if (rgb !== 12'h000) begin fails++;
                    $display("FAIL checker_32_32: got %h want 000", rgb); end
            end
            if (rgb !== exp_rgb(hh, vv, 2)) e_rgb++;
        end
        tests++; if (e_rgb !== 0) begin fails++;
            $display("FAIL checker_rgb: got %0d bad cycles want 0", e_rgb); end
    endtask

    task automatic test_reset_midframe;
        tests++; if (rgb !== 12'hFFF || de_o !== 1'b1) begin fails++;
            $display("FAIL pre_reset: got %h/%b want FFF/1", rgb, de_o); end
        #2;
        reset_i = 1'b1;
        mode_i  = 2'd0;
        #1;
        tests++; if (rgb !== 12'h000 || de_o !== 1'b0) begin fails++;
            $display("FAIL async_reset_rgb_de: got %h/%b want 000/0", rgb, de_o); end
        tests++; if (x_o !== 11'd0 || y_o !== 11'd0) begin fails++;
            $display("FAIL async_reset_xy: got %0d,%0d want 0,0", x_o, y_o); end
        tests++; if (hsync_o !== 1'b1 || vsync_o !== 1'b1 || hsync2 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_sync: got %b%b%b want 110",
                     hsync_o, vsync_o, hsync2); end
        tick;
        reset_i = 1'b0;
        tests++; if (x_o !== 11'd0 || y_o !== 11'd0 || pixel_req_o !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_origin: got %0d,%0d req %b want 0,0 req 1",
                     x_o, y_o, pixel_req_o); end
    endtask

    task automatic test_ext_pixel;
        int hh, vv, e_rgb;
        e_rgb = 0;
        for (int k = 0; k < 2 * HT; k++) begin
            tick;
            hh = k % HT;
            vv = k / HT;
            if (k == 0) begin
                tests++; if (frame_start_o !== 1'b1 || rgb !== 12'h00A) begin fails++;
                    $display("FAIL ext_first: got fs %b rgb %h want fs 1 rgb 00A",
                             frame_start_o, rgb); end
            end
            if (k == 5) begin
                tests++; if (rgb !== 12'h50A) begin fails++;
                    $display("FAIL ext_x5: got %h want 50A", rgb); end
            end
            if (k == HT + 3) begin
                tests++; if (rgb !== 12'h31A) begin fails++;
                    $display("FAIL ext_x3_y1: got %h want 31A", rgb); end
            end
            if (rgb !== exp_rgb(hh, vv, 0)) e_rgb++;
        end
        tests++; if (e_rgb !== 0) begin fails++;
            $display("FAIL ext_rgb: got %0d bad cycles want 0", e_rgb); end
    endtask

    initial begin
        test_reset;
        test_frame_bars;
        test_checker;
        test_reset_midframe;
        test_ext_pixel;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
